ram_access_arbiter: RTL



---
 rtl/ram_arb_pkg.sv | 28 ++
 rtl/rr_arbiter.sv | 32 +++
 rtl/ram_access_arbiter.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the RAM access arbiter: FSM states, RWn encoding
// and the command record latched when a requester is accepted.
package ram_arb_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;

    localparam logic RWN_READ  = 1'b1;
    localparam logic RWN_WRITE = 1'b0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RDCAP  = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic                  rwn;
        logic [ADDR_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] wdata;
    } ram_cmd_t;

    // Round-robin pointer width; a single requester still needs a 1-bit pointer.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first set request found searching
// upward from ptr_i with wrap-around. The pointer itself lives in the parent.
module rr_arbiter
    import ram_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int PTR_W   = ptr_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   ptr_i,
    input  logic               en_i,
    output logic [NUM_REQ-1:0] grant_o
);

    int idx;

    // Scan from lowest priority to highest so the closest requester to ptr wins.
    always_comb begin
        grant_o = '0;
        idx     = 0;
        if (en_i) begin
            for (int k = NUM_REQ - 1; k >= 0; k--) begin
                idx = (int'(ptr_i) + k) % NUM_REQ;
                if (req_i[idx]) begin
                    grant_o      = '0;
                    grant_o[idx] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/ram_access_arbiter.sv
// Shares one synchronous RAM port between NUM_REQ requesters, one access per
// accepted command, round-robin arbitration, read data routed back to the issuer.
module ram_access_arbiter
    import ram_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ-1:0]        req_rwn,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic [NUM_REQ-1:0]        wr_done,
    output logic                      busy,
    output logic                      ram_en,
    output logic                      ram_rwn,
    output logic [ADDR_W-1:0]         ram_raddr,
    output logic [ADDR_W-1:0]         ram_waddr,
    output logic [DATA_W-1:0]         ram_wdata,
    input  logic [DATA_W-1:0]         ram_rdata
);

    localparam int PTR_W = ptr_width(NUM_REQ);

    typedef struct packed {
        logic              rwn;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } cmd_t;

    arb_state_e         state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [NUM_REQ-1:0] owner_q;
    logic               rwn_q;
    logic               ram_en_q, ram_rwn_q;
    logic [ADDR_W-1:0]  ram_raddr_q, ram_waddr_q;
    logic [DATA_W-1:0]  ram_wdata_q;
    logic [NUM_REQ-1:0] wr_done_q;
    logic [DATA_W-1:0]  rsp_rdata_q;

    logic               arb_en;
    logic               accept;
    logic [NUM_REQ-1:0] grant;
    logic [PTR_W-1:0]   grant_idx;
    cmd_t               grant_cmd;

    logic [ADDR_W-1:0]  addr_arr  [NUM_REQ];
    logic [DATA_W-1:0]  wdata_arr [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign addr_arr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
        assign wdata_arr[gi] = req_wdata[gi*DATA_W +: DATA_W];
    end

    // Reset also blocks acceptance so no command can slip in while rst is held.
    assign arb_en = (state_q == IDLE) && !rst;

    rr_arbiter #(
        .NUM_REQ(NUM_REQ),
        .PTR_W  (PTR_W)
    ) u_rr (
        .req_i  (req_valid),
        .ptr_i  (ptr_q),
        .en_i   (arb_en),
        .grant_o(grant)
    );

    assign accept = |grant;

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) grant_idx = PTR_W'(i);
        end
        grant_cmd.rwn   = req_rwn[grant_idx];
        grant_cmd.addr  = addr_arr[grant_idx];
        grant_cmd.wdata = wdata_arr[grant_idx];
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = ACCESS;
                    ptr_d   = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
                end
            end
            ACCESS:  state_d = (rwn_q == RWN_READ) ? RDCAP : IDLE;
            RDCAP:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            owner_q     <= '0;
            rwn_q       <= RWN_READ;
            ram_en_q    <= 1'b0;
            ram_rwn_q   <= RWN_READ;
            ram_raddr_q <= '0;
            ram_waddr_q <= '0;
            ram_wdata_q <= '0;
            wr_done_q   <= '0;
            rsp_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            // RAM strobes are loaded at acceptance so they are live exactly in ACCESS.
            ram_en_q  <= accept;
            ram_rwn_q <= accept ? grant_cmd.rwn : RWN_READ;
            wr_done_q <= '0;
            if (accept) begin
                owner_q <= grant;
                rwn_q   <= grant_cmd.rwn;
                if (grant_cmd.rwn == RWN_READ) begin
                    ram_raddr_q <= grant_cmd.addr;
                end else begin
                    ram_waddr_q <= grant_cmd.addr;
                    ram_wdata_q <= grant_cmd.wdata;
                end
            end
            if (state_q == ACCESS && rwn_q == RWN_WRITE) wr_done_q <= owner_q;
            if (state_q == RDCAP) rsp_rdata_q <= ram_rdata;
        end
    end

    // Read data is forwarded straight from the RAM in RDCAP and held afterwards.
    assign req_ready = grant;
    assign busy      = (state_q != IDLE);
    assign rsp_valid = (state_q == RDCAP && !rst) ? owner_q : '0;
    assign rsp_rdata = (state_q == RDCAP && !rst) ? ram_rdata : rsp_rdata_q;
    assign wr_done   = wr_done_q;
    assign ram_en    = ram_en_q;
    assign ram_rwn   = ram_rwn_q;
    assign ram_raddr = ram_raddr_q;
    assign ram_waddr = ram_waddr_q;
    assign ram_wdata = ram_wdata_q;

endmodule
